// File: rtl/bus_periph_adapter_pkg.sv
// Shared types and constants for the pulsed-bus to req/ack peripheral adapter.
package bus_periph_adapter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RESPOND  = 2'd2
  } periph_adapter_state_t;

  localparam logic [3:0]  BE_FULL_WORD = 4'hF;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // A write with no byte lanes flagged means a full-word write; reads carry no enables.
  function automatic logic [3:0] select_be(input logic we, input logic [3:0] we_ram);
    logic [3:0] be;
    if (!we) begin
      be = 4'h0;
    end else if (we_ram != 4'h0) begin
      be = we_ram;
    end else begin
      be = BE_FULL_WORD;
    end
    return be;
  endfunction

endpackage

// File: rtl/bus_periph_adapter_if.sv
// Bundle of the pulsed bus request/response and the level req/ack peripheral signals.
interface bus_periph_adapter_if #(
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned DataWidth    = 32
);
  logic [AddressWidth-1:0] bus_address_i;
  logic [DataWidth-1:0]    bus_data_i;
  logic                    bus_we_i;
  logic [3:0]              bus_we_ram_i;
  logic [DataWidth-1:0]    bus_rdata_o;
  logic                    module_busy_o;
  logic                    per_req_o;
  logic                    per_we_o;
  logic [AddressWidth-1:0] per_addr_o;
  logic [DataWidth-1:0]    per_wdata_o;
  logic [3:0]              per_be_o;
  logic                    per_ack_i;
  logic [DataWidth-1:0]    per_rdata_i;
  logic                    req_dropped_o;

  modport slave (
    input  bus_address_i, bus_data_i, bus_we_i, bus_we_ram_i, per_ack_i, per_rdata_i,
    output bus_rdata_o, module_busy_o, per_req_o, per_we_o, per_addr_o, per_wdata_o,
           per_be_o, req_dropped_o
  );

  modport master (
    output bus_address_i, bus_data_i, bus_we_i, bus_we_ram_i, per_ack_i, per_rdata_i,
    input  bus_rdata_o, module_busy_o, per_req_o, per_we_o, per_addr_o, per_wdata_o,
           per_be_o, req_dropped_o
  );
endinterface

// File: rtl/bus_periph_adapter_timeout_counter.sv
// WAIT_ACK watchdog for the peripheral adapter; only built when BUS_PERIPH_ADAPTER_TIMEOUT_EN is defined.
`ifdef BUS_PERIPH_ADAPTER_TIMEOUT_EN
module bus_timeout_counter #(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic expired_o
);
  localparam int unsigned      CW   = $clog2(TimeoutCycles) + 1;
  localparam logic [CW-1:0]    LAST = CW'(TimeoutCycles - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Count WAIT_ACK cycles, restarting on each new access and saturating at the limit.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {CW{1'b0}};
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == LAST);
endmodule
`endif

// File: rtl/bus_periph_adapter.sv
// Converts one-cycle pulsed bus requests into a level req/ack peripheral access, holding busy meanwhile.
// Optional WAIT_ACK timeout is enabled by defining BUS_PERIPH_ADAPTER_TIMEOUT_EN.
module bus_periph_adapter
  import bus_periph_adapter_pkg::*;
#(
  parameter int unsigned             AddressWidth  = 32,
  parameter int unsigned             DataWidth     = 32,
  parameter logic [AddressWidth-1:0] BaseAddress   = 32'h0000_9000,
  parameter logic [AddressWidth-1:0] EndAddress    = 32'h0000_90FF,
  parameter int unsigned             TimeoutCycles = 1024,
  parameter logic [DataWidth-1:0]    TimeoutData   = TIMEOUT_DATA
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  bus_periph_adapter_if.slave bus
);
  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_WAIT_ACK = WAIT_ACK;
  localparam logic [1:0] ST_RESPOND  = RESPOND;

  // The idle bus drives address 0, so a zero base would decode idle cycles as requests.
  if (BaseAddress == {AddressWidth{1'b0}}) begin : g_base_zero
    $error("bus_periph_adapter: BaseAddress must be nonzero");
  end
  if (EndAddress < BaseAddress) begin : g_end_low
    $error("bus_periph_adapter: EndAddress must not be below BaseAddress");
  end
  if (TimeoutCycles < 32'd2) begin : g_tmo_small
    $error("bus_periph_adapter: TimeoutCycles must be at least 2");
  end

  logic [1:0]              state_q, state_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic [3:0]              be_q, be_d;
  logic                    req_q, req_d;
  logic                    busy_q, busy_d;
  logic [DataWidth-1:0]    rdata_q, rdata_d;
  logic                    dropped_q, dropped_d;
  logic                    hit_s;
  logic                    accept_s;
  logic                    tmo_expired_s;

  assign hit_s    = (bus.bus_address_i >= BaseAddress) && (bus.bus_address_i <= EndAddress);
  assign accept_s = (state_q == ST_IDLE) && hit_s;

`ifdef BUS_PERIPH_ADAPTER_TIMEOUT_EN
  bus_timeout_counter #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .enable_i  (state_q == ST_WAIT_ACK),
    .clear_i   (accept_s),
    .expired_o (tmo_expired_s)
  );
`else
  assign tmo_expired_s = 1'b0;
`endif

  // Next-state and output-register logic for the IDLE -> WAIT_ACK -> RESPOND cycle.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    be_d      = be_q;
    req_d     = req_q;
    busy_d    = busy_q;
    rdata_d   = rdata_q;
    dropped_d = dropped_q;
    case (state_q)
      ST_IDLE: begin
        if (hit_s) begin
          addr_d  = bus.bus_address_i - BaseAddress;
          wdata_d = bus.bus_data_i;
          we_d    = bus.bus_we_i;
          be_d    = select_be(bus.bus_we_i, bus.bus_we_ram_i);
          req_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_WAIT_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        if (hit_s) begin
          dropped_d = 1'b1;
        end else begin
          dropped_d = dropped_q;
        end
        // Ack takes priority over a timeout expiring in the same cycle.
        if (bus.per_ack_i) begin
          req_d   = 1'b0;
          rdata_d = we_q ? {DataWidth{1'b0}} : bus.per_rdata_i;
          state_d = ST_RESPOND;
        end else if (tmo_expired_s) begin
          req_d   = 1'b0;
          rdata_d = we_q ? {DataWidth{1'b0}} : TimeoutData;
          state_d = ST_RESPOND;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_RESPOND: begin
        if (hit_s) begin
          dropped_d = 1'b1;
        end else begin
          dropped_d = dropped_q;
        end
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= {AddressWidth{1'b0}};
      wdata_q   <= {DataWidth{1'b0}};
      we_q      <= 1'b0;
      be_q      <= 4'h0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= {DataWidth{1'b0}};
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      be_q      <= be_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      rdata_q   <= rdata_d;
      dropped_q <= dropped_d;
    end
  end

  assign bus.per_addr_o    = addr_q;
  assign bus.per_wdata_o   = wdata_q;
  assign bus.per_we_o      = we_q;
  assign bus.per_be_o      = be_q;
  assign bus.per_req_o     = req_q;
  assign bus.module_busy_o = busy_q;
  assign bus.bus_rdata_o   = rdata_q;
  assign bus.req_dropped_o = dropped_q;
endmodule

// File: tb/tb_bus_periph_adapter.sv
// Scoreboard bench for bus_periph_adapter: expected transactions are queued at issue and checked at req/busy edges.
`timescale 1ns/1ps
module tb_bus_periph_adapter;
  localparam logic [31:0] BASE  = 32'h0000_9000;
  localparam logic [31:0] END_A = 32'h0000_90FF;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  txn_t exp_q[$];

  bus_periph_adapter_if #(.AddressWidth(32), .DataWidth(32)) bus ();

  bus_periph_adapter #(
    .AddressWidth (32),
    .DataWidth    (32),
    .BaseAddress  (BASE),
    .EndAddress   (END_A),
    .TimeoutCycles(16),
    .TimeoutData  (32'hDEAD_BEEF)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.bus_address_i = 32'h0;
    bus.bus_data_i    = 32'h0;
    bus.bus_we_i      = 1'b0;
    bus.bus_we_ram_i  = 4'h0;
  endtask

  // One-cycle bus pulse; accepted requests push their expected peripheral view and response.
  task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] we_ram,
                       input logic [31:0] d, input logic [31:0] rd_exp, input bit accept);
    txn_t t;
    if (accept) begin
      t.addr  = a - BASE;
      t.we    = we;
      t.be    = !we ? 4'h0 : ((we_ram != 4'h0) ? we_ram : 4'hF);
      t.wdata = d;
      t.rdata = we ? 32'h0 : rd_exp;
      exp_q.push_back(t);
    end
    bus.bus_address_i = a;
    bus.bus_we_i      = we;
    bus.bus_we_ram_i  = we_ram;
    bus.bus_data_i    = d;
    cyc();
    idle_bus();
  endtask

  // Peripheral model: ack after 'delay' cycles (negative = never), optional bus pulse at cycle inj_k.
  task automatic respond(input int delay, input logic [31:0] rd, input int inj_k,
                         input logic [31:0] inj_a, output int busy_n, output int req_n);
    busy_n = 0;
    req_n  = 0;
    for (int k = 0; k < 64; k++) begin
      if (!bus.module_busy_o) break;
      busy_n++;
      if (bus.per_req_o) req_n++;
      bus.per_ack_i     = (k == delay);
      bus.per_rdata_i   = (k == delay) ? rd : 32'h0;
      bus.bus_address_i = (k == inj_k) ? inj_a : 32'h0;
      cyc();
    end
    bus.per_ack_i     = 1'b0;
    bus.per_rdata_i   = 32'h0;
    bus.bus_address_i = 32'h0;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    checks++;
    if ({bus.bus_rdata_o, bus.module_busy_o, bus.per_req_o, bus.per_we_o, bus.per_addr_o,
         bus.per_wdata_o, bus.per_be_o, bus.req_dropped_o} !== 104'h0)
      begin failures++; $display("FAIL reset_outputs got busy=%b req=%b addr=%h rdata=%h want all 0",
                                 bus.module_busy_o, bus.per_req_o, bus.per_addr_o, bus.bus_rdata_o); end
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_read();
    txn_t t; int bn; int rn;
    issue(BASE + 32'd4, 1'b0, 4'h0, 32'h0, 32'h1234_5678, 1'b1);
    t = exp_q.pop_front();
    checks++; if (bus.per_req_o !== 1'b1) begin failures++; $display("FAIL read_req got=%b want=1", bus.per_req_o); end
    checks++; if (bus.per_addr_o !== t.addr) begin failures++; $display("FAIL read_addr got=%h want=%h", bus.per_addr_o, t.addr); end
    checks++; if (bus.per_be_o !== t.be) begin failures++; $display("FAIL read_be got=%h want=%h", bus.per_be_o, t.be); end
    checks++; if (bus.per_we_o !== t.we) begin failures++; $display("FAIL read_we got=%b want=%b", bus.per_we_o, t.we); end
    respond(5, 32'h1234_5678, -1, 32'h0, bn, rn);
    checks++; if (bn !== 7) begin failures++; $display("FAIL read_busy_cycles got=%0d want=7", bn); end
    checks++; if (bus.bus_rdata_o !== t.rdata) begin failures++; $display("FAIL read_rdata got=%h want=%h", bus.bus_rdata_o, t.rdata); end
  endtask

  task automatic test_write();
    txn_t t; int bn; int rn;
    issue(BASE, 1'b1, 4'h0, 32'hA5A5_0001, 32'h0, 1'b1);
    t = exp_q.pop_front();
    checks++; if (bus.per_be_o !== t.be) begin failures++; $display("FAIL write_be_full got=%h want=%h", bus.per_be_o, t.be); end
    checks++; if (bus.per_wdata_o !== t.wdata) begin failures++; $display("FAIL write_wdata got=%h want=%h", bus.per_wdata_o, t.wdata); end
    checks++; if ({bus.per_we_o, bus.per_addr_o} !== {t.we, t.addr}) begin failures++; $display("FAIL write_we_addr got=%b/%h want=%b/%h", bus.per_we_o, bus.per_addr_o, t.we, t.addr); end
    respond(0, 32'hFFFF_FFFF, -1, 32'h0, bn, rn);
    checks++; if (bn !== 2) begin failures++; $display("FAIL write_busy_cycles got=%0d want=2", bn); end
    checks++; if (bus.bus_rdata_o !== t.rdata) begin failures++; $display("FAIL write_rdata got=%h want=%h", bus.bus_rdata_o, t.rdata); end
    issue(BASE + 32'h20, 1'b1, 4'h3, 32'h0000_00C3, 32'h0, 1'b1);
    t = exp_q.pop_front();
    checks++; if (bus.per_be_o !== t.be) begin failures++; $display("FAIL write_be_partial got=%h want=%h", bus.per_be_o, t.be); end
    respond(2, 32'h0, -1, 32'h0, bn, rn);
    checks++; if (bn !== 4) begin failures++; $display("FAIL write2_busy_cycles got=%0d want=4", bn); end
  endtask

  task automatic test_boundary();
    txn_t t; int bn; int rn; bit seen;
    logic [31:0] oor [3];
    oor[0] = END_A + 32'd1;
    oor[1] = 32'h0;
    oor[2] = BASE - 32'd1;
    issue(END_A, 1'b0, 4'h0, 32'h0, 32'hCAFE_0001, 1'b1);
    t = exp_q.pop_front();
    checks++; if (bus.per_addr_o !== t.addr) begin failures++; $display("FAIL end_addr got=%h want=%h", bus.per_addr_o, t.addr); end
    respond(1, 32'hCAFE_0001, -1, 32'h0, bn, rn);
    checks++; if (bus.bus_rdata_o !== t.rdata) begin failures++; $display("FAIL end_rdata got=%h want=%h", bus.bus_rdata_o, t.rdata); end
    for (int i = 0; i < 3; i++) begin
      issue(oor[i], 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
        seen = seen | bus.per_req_o | bus.module_busy_o;
        cyc();
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL out_of_range_%0d got req/busy=%b want=0", i, seen); end
    end
    bus.per_ack_i   = 1'b1;
    bus.per_rdata_i = 32'h1111_1111;
    cyc();
    bus.per_ack_i   = 1'b0;
    bus.per_rdata_i = 32'h0;
    cyc();
    checks++; if ({bus.module_busy_o, bus.bus_rdata_o} !== {1'b0, t.rdata}) begin failures++; $display("FAIL idle_ack_ignored got=%b/%h want=0/%h", bus.module_busy_o, bus.bus_rdata_o, t.rdata); end
  endtask

  task automatic test_overlap();
    txn_t t; int bn; int rn;
    issue(BASE + 32'h8, 1'b0, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b1);
    t = exp_q.pop_front();
    respond(4, 32'h0BAD_F00D, 2, BASE + 32'h10, bn, rn);
    checks++; if (bus.req_dropped_o !== 1'b1) begin failures++; $display("FAIL overlap_dropped got=%b want=1", bus.req_dropped_o); end
    checks++; if (bn !== 6) begin failures++; $display("FAIL overlap_busy_cycles got=%0d want=6", bn); end
    checks++; if ({bus.per_addr_o, bus.bus_rdata_o} !== {t.addr, t.rdata}) begin failures++; $display("FAIL overlap_first_txn got=%h/%h want=%h/%h", bus.per_addr_o, bus.bus_rdata_o, t.addr, t.rdata); end
    repeat (3) cyc();
    checks++; if ({bus.per_req_o, bus.module_busy_o, bus.req_dropped_o} !== 3'b001) begin failures++; $display("FAIL overlap_after got=%b want=001", {bus.per_req_o, bus.module_busy_o, bus.req_dropped_o}); end
  endtask

  task automatic test_async_reset();
    txn_t t; int bn; int rn;
    issue(BASE + 32'hC, 1'b1, 4'h5, 32'h0000_0077, 32'h0, 1'b1);
    t = exp_q.pop_front();
    checks++; if (bus.per_be_o !== t.be) begin failures++; $display("FAIL rst_txn_be got=%h want=%h", bus.per_be_o, t.be); end
    cyc();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.bus_rdata_o, bus.module_busy_o, bus.per_req_o, bus.per_we_o, bus.per_addr_o,
         bus.per_wdata_o, bus.per_be_o, bus.req_dropped_o} !== 104'h0)
      begin failures++; $display("FAIL async_reset got busy=%b req=%b dropped=%b be=%h want all 0",
                                 bus.module_busy_o, bus.per_req_o, bus.req_dropped_o, bus.per_be_o); end
    cyc();
    cyc();
    reset_n = 1'b1;
    issue(BASE + 32'h14, 1'b0, 4'h0, 32'h0, 32'h5555_AAAA, 1'b1);
    t = exp_q.pop_front();
    checks++; if ({bus.per_req_o, bus.per_addr_o} !== {1'b1, t.addr}) begin failures++; $display("FAIL post_reset_req got=%b/%h want=1/%h", bus.per_req_o, bus.per_addr_o, t.addr); end
    respond(3, 32'h5555_AAAA, -1, 32'h0, bn, rn);
    checks++; if ({bus.bus_rdata_o, bus.req_dropped_o} !== {t.rdata, 1'b0}) begin failures++; $display("FAIL post_reset_read got=%h/%b want=%h/0", bus.bus_rdata_o, bus.req_dropped_o, t.rdata); end
  endtask

  task automatic test_respond_drop();
    txn_t t; int bn; int rn; bit seen;
    issue(BASE + 32'h18, 1'b0, 4'h0, 32'h0, 32'h0000_0042, 1'b1);
    t = exp_q.pop_front();
    respond(1, 32'h0000_0042, 2, BASE + 32'h1C, bn, rn);
    checks++; if ({bus.req_dropped_o, bus.bus_rdata_o} !== {1'b1, t.rdata}) begin failures++; $display("FAIL respond_drop got=%b/%h want=1/%h", bus.req_dropped_o, bus.bus_rdata_o, t.rdata); end
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen = seen | bus.per_req_o;
      cyc();
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL respond_drop_no_req got=%b want=0", seen); end
  endtask

`ifdef BUS_PERIPH_ADAPTER_TIMEOUT_EN
  task automatic test_timeout();
    txn_t t; int bn; int rn;
    issue(BASE + 32'h40, 1'b0, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1);
    t = exp_q.pop_front();
    respond(-1, 32'h0, -1, 32'h0, bn, rn);
    checks++; if ({rn, bn} !== {32'd16, 32'd17}) begin failures++; $display("FAIL timeout_cycles got req=%0d busy=%0d want 16/17", rn, bn); end
    checks++; if (bus.bus_rdata_o !== t.rdata) begin failures++; $display("FAIL timeout_rdata got=%h want=%h", bus.bus_rdata_o, t.rdata); end
    issue(BASE + 32'h44, 1'b0, 4'h0, 32'h0, 32'h0123_4567, 1'b1);
    t = exp_q.pop_front();
    respond(15, 32'h0123_4567, -1, 32'h0, bn, rn);
    checks++; if ({rn, bn} !== {32'd16, 32'd17}) begin failures++; $display("FAIL ack_vs_timeout_cycles got req=%0d busy=%0d want 16/17", rn, bn); end
    checks++; if (bus.bus_rdata_o !== t.rdata) begin failures++; $display("FAIL ack_vs_timeout_rdata got=%h want=%h", bus.bus_rdata_o, t.rdata); end
  endtask
`endif

  initial begin
    idle_bus();
    bus.per_ack_i   = 1'b0;
    bus.per_rdata_i = 32'h0;
    test_reset();
    test_read();
    test_write();
    test_boundary();
    test_overlap();
    test_async_reset();
    test_respond_drop();
`ifdef BUS_PERIPH_ADAPTER_TIMEOUT_EN
    test_timeout();
`endif
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
